// File: rtl/mag_cmp_seq.sv
// Sequential NCH-channel magnitude comparator: max/min with indices, all-equal and ch0-vs-ch1 flags.
// Define MAG_CMP_SIGNED_EN to treat operands as two's-complement signed values.
module mag_cmp_seq #(
    parameter  int unsigned WIDTH = 3,
    parameter  int unsigned NCH   = 2,
    localparam int unsigned IDXW  = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       max_val,
    output logic [IDXW-1:0]        max_idx,
    output logic [WIDTH-1:0]       min_val,
    output logic [IDXW-1:0]        min_idx,
    output logic                   all_eq,
    output logic                   a_gt_b,
    output logic                   a_lt_b,
    output logic                   a_eq_b
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [NCH-1:0][WIDTH-1:0]   data_q;
    logic [IDXW-1:0]             cnt;
    logic [WIDTH-1:0]            cur_op;
    logic [WIDTH-1:0]            in_ch0;
    logic [WIDTH-1:0]            in_ch1;

    // Strict greater-than in the selected number system
    function automatic logic op_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MAG_CMP_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign cur_op   = data_q[cnt];
    assign in_ch0   = in_data[WIDTH-1:0];
    assign in_ch1   = in_data[2*WIDTH-1:WIDTH];

    // Accept a vector, then fold one channel per cycle into the running max/min
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            max_val   <= '0;
            max_idx   <= '0;
            min_val   <= '0;
            min_idx   <= '0;
            all_eq    <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        max_val <= in_ch0;
                        min_val <= in_ch0;
                        max_idx <= '0;
                        min_idx <= '0;
                        all_eq  <= 1'b1;
                        cnt     <= IDXW'(1);
                        a_gt_b  <= op_gt(in_ch0, in_ch1);
                        a_lt_b  <= op_gt(in_ch1, in_ch0);
                        a_eq_b  <= (in_ch0 == in_ch1);
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict comparisons keep the lowest index on ties
                    if (op_gt(cur_op, max_val)) begin
                        max_val <= cur_op;
                        max_idx <= cnt;
                    end
                    if (op_gt(min_val, cur_op)) begin
                        min_val <= cur_op;
                        min_idx <= cnt;
                    end
                    if (cur_op != data_q[0]) begin
                        all_eq <= 1'b0;
                    end
                    if (cnt == IDXW'(NCH - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Bench for mag_cmp_seq: three instances (NCH=2,3,4, WIDTH=3), table vectors, corner sequences, random vs model.
module tb_mag_cmp_seq;

    typedef struct {
        int         n;
        logic [11:0] d;
        logic [2:0] maxv;
        logic [1:0] maxi;
        logic [2:0] minv;
        logic [1:0] mini;
        logic       ae;
        logic       gt;
        logic       lt;
        logic       eq;
    } vec_t;

    typedef struct {
        logic       ov;
        logic       rdy;
        logic [2:0] maxv;
        logic [1:0] maxi;
        logic [2:0] minv;
        logic [1:0] mini;
        logic       ae;
        logic       gt;
        logic       lt;
        logic       eq;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:2]  in_valid;
    logic [4:2]  out_ready;
    logic [11:0] in_data [2:4];

    logic       ov2, rdy2, ae2, gt2, lt2, eq2;
    logic [2:0] maxv2, minv2;
    logic [0:0] maxi2, mini2;
    logic       ov3, rdy3, ae3, gt3, lt3, eq3;
    logic [2:0] maxv3, minv3;
    logic [1:0] maxi3, mini3;
    logic       ov4, rdy4, ae4, gt4, lt4, eq4;
    logic [2:0] maxv4, minv4;
    logic [1:0] maxi4, mini4;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mag_cmp_seq #(.WIDTH(3), .NCH(2)) u_n2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2),
        .in_data(in_data[2][5:0]), .out_valid(ov2), .out_ready(out_ready[2]),
        .max_val(maxv2), .max_idx(maxi2), .min_val(minv2), .min_idx(mini2),
        .all_eq(ae2), .a_gt_b(gt2), .a_lt_b(lt2), .a_eq_b(eq2));

    mag_cmp_seq #(.WIDTH(3), .NCH(3)) u_n3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(rdy3),
        .in_data(in_data[3][8:0]), .out_valid(ov3), .out_ready(out_ready[3]),
        .max_val(maxv3), .max_idx(maxi3), .min_val(minv3), .min_idx(mini3),
        .all_eq(ae3), .a_gt_b(gt3), .a_lt_b(lt3), .a_eq_b(eq3));

    mag_cmp_seq #(.WIDTH(3), .NCH(4)) u_n4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(rdy4),
        .in_data(in_data[4]), .out_valid(ov4), .out_ready(out_ready[4]),
        .max_val(maxv4), .max_idx(maxi4), .min_val(minv4), .min_idx(mini4),
        .all_eq(ae4), .a_gt_b(gt4), .a_lt_b(lt4), .a_eq_b(eq4));

    function automatic res_t get(input int n);
        res_t r;
        case (n)
            2: r = '{ov2, rdy2, maxv2, {1'b0, maxi2}, minv2, {1'b0, mini2}, ae2, gt2, lt2, eq2};
            3: r = '{ov3, rdy3, maxv3, maxi3, minv3, mini3, ae3, gt3, lt3, eq3};
            default: r = '{ov4, rdy4, maxv4, maxi4, minv4, mini4, ae4, gt4, lt4, eq4};
        endcase
        return r;
    endfunction

    function automatic int sval(input logic [2:0] x);
`ifdef MAG_CMP_SIGNED_EN
        return x[2] ? int'(x) - 8 : int'(x);
`else
        return int'(x);
`endif
    endfunction

    // Reference: extreme values first, then the first channel holding each
    function automatic vec_t model(input int n, input logic [11:0] d);
        vec_t e;
        logic [2:0] raw [4];
        int v [4];
        int mx, mn;
        for (int k = 0; k < 4; k++) begin
            raw[k] = d[k*3 +: 3];
            v[k]   = sval(raw[k]);
        end
        mx = v[0];
        mn = v[0];
        for (int k = 1; k < n; k++) begin
            mx = (v[k] > mx) ? v[k] : mx;
            mn = (v[k] < mn) ? v[k] : mn;
        end
        e.n = n;
        e.d = d;
        for (int k = n - 1; k >= 0; k--) begin
            if (v[k] == mx) e.maxi = 2'(k);
            if (v[k] == mn) e.mini = 2'(k);
        end
        e.maxv = raw[e.maxi];
        e.minv = raw[e.mini];
        e.ae = 1'b1;
        for (int k = 1; k < n; k++) if (raw[k] != raw[0]) e.ae = 1'b0;
        e.gt = v[0] > v[1];
        e.lt = v[0] < v[1];
        e.eq = raw[0] == raw[1];
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input vec_t e);
        res_t r;
        r = get(e.n);
        chk({tag, " out_valid"}, int'(r.ov), 1);
        chk({tag, " max_val"}, int'(r.maxv), int'(e.maxv));
        chk({tag, " max_idx"}, int'(r.maxi), int'(e.maxi));
        chk({tag, " min_val"}, int'(r.minv), int'(e.minv));
        chk({tag, " min_idx"}, int'(r.mini), int'(e.mini));
        chk({tag, " all_eq"}, int'(r.ae), int'(e.ae));
        chk({tag, " a_gt_b"}, int'(r.gt), int'(e.gt));
        chk({tag, " a_lt_b"}, int'(r.lt), int'(e.lt));
        chk({tag, " a_eq_b"}, int'(r.eq), int'(e.eq));
    endtask

    // Present a vector, wait for acceptance, then count edges until out_valid
    task automatic send(input int n, input logic [11:0] d, output int lat, output logic ok);
        int t;
        res_t r;
        ok  = 1'b1;
        lat = 0;
        @(negedge clk);
        in_valid[n] = 1'b1;
        in_data[n]  = d;
        t = 0;
        r = get(n);
        while (!r.rdy && t < 20) begin
            @(negedge clk);
            t++;
            r = get(n);
        end
        if (!r.rdy) begin
            $display("FAIL accept timeout n=%0d: in_ready got 0 expected 1", n);
            err_cnt++;
            cmp_cnt++;
            in_valid[n] = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[n] = 1'b0;
        in_data[n]  = ~d;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            r = get(n);
        end while (!r.ov && lat < 40);
        if (!r.ov) begin
            $display("FAIL result timeout n=%0d: out_valid got 0 expected 1", n);
            err_cnt++;
            cmp_cnt++;
            ok = 1'b0;
        end
    endtask

    task automatic finish_rx(input string tag, input int n);
        res_t r;
        @(posedge clk);
        @(negedge clk);
        r = get(n);
        chk({tag, " out_valid after handshake"}, int'(r.ov), 0);
        chk({tag, " in_ready after handshake"}, int'(r.rdy), 1);
    endtask

    task automatic run_vec(input string tag, input vec_t e);
        int lat;
        logic ok;
        send(e.n, e.d, lat, ok);
        if (ok) begin
            chk({tag, " latency"}, lat, e.n - 1);
            chk_res(tag, e);
            finish_rx(tag, e.n);
        end
    endtask

    vec_t tbl [6];

    initial begin
        res_t r;
        vec_t e;
        int lat;
        logic ok;
        logic seen;

`ifdef MAG_CMP_SIGNED_EN
        tbl[0] = '{2, 12'o0035, 3'd3, 2'd1, 3'd5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3, 12'o0772, 3'd2, 2'd0, 3'd7, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{2, 12'o0017, 3'd1, 2'd1, 3'd7, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{4, 12'o6061, 3'd1, 2'd0, 3'd6, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        tbl[0] = '{2, 12'o0035, 3'd5, 2'd0, 3'd3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{3, 12'o0772, 3'd7, 2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{2, 12'o0017, 3'd7, 2'd0, 3'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{4, 12'o6061, 3'd6, 2'd1, 3'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        tbl[2] = '{3, 12'o0444, 3'd4, 2'd0, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{4, 12'o0123, 3'd3, 2'd0, 3'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held with in_valid asserted
        rst       = 1'b1;
        in_valid  = 3'b111;
        out_ready = 3'b111;
        for (int n = 2; n <= 4; n++) in_data[n] = 12'hfff;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int n = 2; n <= 4; n++) begin
            r = get(n);
            chk($sformatf("reset n=%0d in_ready", n), int'(r.rdy), 0);
            chk($sformatf("reset n=%0d out_valid", n), int'(r.ov), 0);
            chk($sformatf("reset n=%0d outputs", n),
                int'({r.maxv, r.maxi, r.minv, r.mini, r.ae, r.gt, r.lt, r.eq}), 0);
        end
        rst      = 1'b0;
        in_valid = 3'b000;
        @(posedge clk);
        @(negedge clk);
        for (int n = 2; n <= 4; n++) begin
            r = get(n);
            chk($sformatf("post-reset n=%0d in_ready", n), int'(r.rdy), 1);
        end

        for (int i = 0; i < 6; i++) run_vec($sformatf("tbl[%0d]", i), tbl[i]);

        // Reset one cycle into a scan aborts it
        @(negedge clk);
        in_valid[4] = 1'b1;
        in_data[4]  = 12'o6061;
        @(posedge clk);
        #1;
        in_valid[4] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        r = get(4);
        chk("midscan out_valid", int'(r.ov), 0);
        chk("midscan outputs", int'({r.maxv, r.maxi, r.minv, r.mini, r.ae, r.gt, r.lt, r.eq}), 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= ov4;
        end
        chk("midscan no out_valid", int'(seen), 0);
        run_vec("after midscan", tbl[3]);

        // Backpressure: result held, extra vector ignored
        out_ready[4] = 1'b0;
        send(4, tbl[5].d, lat, ok);
        if (ok) begin
            chk("bp latency", lat, 3);
            in_valid[4] = 1'b1;
            in_data[4]  = 12'o7777;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                @(negedge clk);
                r = get(4);
                chk($sformatf("bp c%0d in_ready", c), int'(r.rdy), 0);
                chk_res($sformatf("bp c%0d", c), tbl[5]);
            end
            in_valid[4]  = 1'b0;
            out_ready[4] = 1'b1;
            finish_rx("bp", 4);
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen |= ov4;
            end
            chk("bp not queued", int'(seen), 0);
        end
        out_ready[4] = 1'b1;

        // Exhaustive NCH=2 pairs
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                logic [11:0] d;
                d = {6'd0, 3'(b), 3'(a)};
                run_vec($sformatf("pair %0d,%0d", a, b), model(2, d));
            end
        end

        // Random vectors across all instances
        for (int i = 0; i < 120; i++) begin
            int n;
            logic [11:0] d;
            n = int'($urandom_range(4, 2));
            d = 12'($urandom);
            e = model(n, d);
            run_vec($sformatf("rand%0d n=%0d d=%0o", i, n, d), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
